// File: rtl/sat_cfg_pkg.sv
// Shared configuration for the learnt-clause slot allocator: FSM states,
// default clause-length width, the empty-slot marker and slot-length extraction.
package sat_cfg_pkg;

    localparam int WIDTH_C_LEN_DEF = 4;
    localparam int EMPTY_LEN       = 0;

    // Upper bounds of the padded vector that slot_len() accepts.
    localparam int MAX_SLOTS = 64;
    localparam int MAX_LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WRITE,
        DONE
    } state_e;

    // Length of slot idx from a flat vector of len_w-bit fields (len_w <= MAX_LEN_W).
    function automatic logic [MAX_LEN_W-1:0] slot_len(
        input logic [MAX_SLOTS*MAX_LEN_W-1:0] flat,
        input int unsigned                    idx,
        input int unsigned                    len_w
    );
        logic [MAX_SLOTS*MAX_LEN_W-1:0] w_shifted;
        w_shifted = flat >> (idx * len_w);
        return w_shifted[MAX_LEN_W-1:0] & MAX_LEN_W'((32'd1 << len_w) - 32'd1);
    endfunction

endpackage

// File: rtl/len_max_tracker.sv
// Registered running maximum of clause length with the index where it was seen.
// Strict '>' keeps the lowest index on ties.
module len_max_tracker #(
    parameter int LEN_W = 4,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_elig,
    input  logic [LEN_W-1:0] i_len,
    input  logic [IDX_W-1:0] i_idx,
    output logic [LEN_W-1:0] o_best_len,
    output logic [IDX_W-1:0] o_best_idx,
    output logic             o_best_vld
);

    logic [LEN_W-1:0] r_best_len;
    logic [IDX_W-1:0] r_best_idx;
    logic             r_best_vld;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_best_len <= '0;
            r_best_idx <= '0;
            r_best_vld <= 1'b0;
        end else if (i_clr) begin
            r_best_len <= '0;
            r_best_idx <= '0;
            r_best_vld <= 1'b0;
        end else if (i_en && i_elig && (!r_best_vld || (i_len > r_best_len))) begin
            r_best_len <= i_len;
            r_best_idx <= i_idx;
            r_best_vld <= 1'b1;
        end
    end

    assign o_best_len = r_best_len;
    assign o_best_idx = r_best_idx;
    assign o_best_vld = r_best_vld;

endmodule

// File: rtl/learntc_slot_alloc.sv
// Learnt-clause slot allocator: passes controller write enables through in IDLE and,
// on an add request, scans the learnt region and issues one one-hot write.
// Optional macro LEARNTC_LOCK_EN excludes locked (reason) slots from replacement.
module learntc_slot_alloc
    import sat_cfg_pkg::*;
#(
    parameter int NUM_CLAUSES = 16,
    parameter int NUM_ORIGIN  = 8,
    parameter int WIDTH_C_LEN = WIDTH_C_LEN_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CLAUSES-1:0]             wr_i,
    output logic [NUM_CLAUSES-1:0]             wr_o,
    input  logic [NUM_CLAUSES*WIDTH_C_LEN-1:0] clause_len_i,
    input  logic                               add_req_i,
    input  logic [WIDTH_C_LEN-1:0]             add_len_i,
    output logic                               add_ack_o,
    output logic                               add_rej_o,
    output logic [$clog2(NUM_CLAUSES)-1:0]     add_idx_o,
    output logic                               replaced_o,
    output logic                               busy_o,
    input  logic [NUM_CLAUSES-1:0]             locked_i
);

    localparam int IDX_W      = $clog2(NUM_CLAUSES);
    localparam int NUM_LEARNT = NUM_CLAUSES - NUM_ORIGIN;
    localparam int FLAT_W     = MAX_SLOTS * MAX_LEN_W;

    state_e                  r_state;
    logic [IDX_W-1:0]        r_ptr;
    logic [IDX_W-1:0]        r_tgt_idx;
    logic [WIDTH_C_LEN-1:0]  r_add_len;
    logic                    r_empty_found;
    logic                    r_scan_end;
    logic [NUM_CLAUSES-1:0]  r_wr;
    logic                    r_ack;
    logic                    r_rej;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_replaced;
    logic                    r_busy;

    logic [FLAT_W-1:0]       w_len_flat;
    logic [WIDTH_C_LEN-1:0]  w_cur_len;
    logic                    w_slot_empty;
    logic                    w_elig;
    logic                    w_trk_clr;
    logic                    w_trk_en;
    logic [WIDTH_C_LEN-1:0]  w_best_len;
    logic [IDX_W-1:0]        w_best_idx;
    logic                    w_best_vld;

    assign w_len_flat   = FLAT_W'(clause_len_i);
    assign w_cur_len    = WIDTH_C_LEN'(slot_len(w_len_flat, 32'(r_ptr), WIDTH_C_LEN));
    assign w_slot_empty = (w_cur_len == WIDTH_C_LEN'(EMPTY_LEN));

`ifdef LEARNTC_LOCK_EN
    assign w_elig = ~locked_i[r_ptr];
`else
    // locked_i is read but has no influence in this build.
    assign w_elig = ~(|(locked_i & '0));
`endif

    assign w_trk_clr = (r_state == IDLE) && add_req_i;
    assign w_trk_en  = (r_state == SCAN) && !r_scan_end && !w_slot_empty;

    len_max_tracker #(
        .LEN_W (WIDTH_C_LEN),
        .IDX_W (IDX_W)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_trk_clr),
        .i_en       (w_trk_en),
        .i_elig     (w_elig),
        .i_len      (w_cur_len),
        .i_idx      (r_ptr),
        .o_best_len (w_best_len),
        .o_best_idx (w_best_idx),
        .o_best_vld (w_best_vld)
    );

    // The last slot's contribution lands in the tracker one cycle later, so a full
    // scan spends one extra SCAN cycle (r_scan_end) judging the final maximum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_tgt_idx     <= '0;
            r_add_len     <= '0;
            r_empty_found <= 1'b0;
            r_scan_end    <= 1'b0;
            r_wr          <= '0;
            r_ack         <= 1'b0;
            r_rej         <= 1'b0;
            r_idx         <= '0;
            r_replaced    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (add_req_i) begin
                        r_add_len     <= add_len_i;
                        r_ptr         <= IDX_W'(NUM_ORIGIN);
                        r_empty_found <= 1'b0;
                        r_scan_end    <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (r_scan_end) begin
                        if (w_best_vld && (r_add_len < w_best_len)) begin
                            r_tgt_idx <= w_best_idx;
                            r_wr      <= NUM_CLAUSES'(1) << w_best_idx;
                            r_state   <= WRITE;
                        end else begin
                            r_ack      <= 1'b1;
                            r_rej      <= 1'b1;
                            r_replaced <= 1'b0;
                            r_state    <= DONE;
                        end
                    end else if (w_slot_empty) begin
                        r_tgt_idx     <= r_ptr;
                        r_empty_found <= 1'b1;
                        r_wr          <= NUM_CLAUSES'(1) << r_ptr;
                        r_state       <= WRITE;
                    end else if (r_ptr == IDX_W'(NUM_CLAUSES - 1)) begin
                        r_scan_end <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                WRITE: begin
                    r_wr       <= '0;
                    r_ack      <= 1'b1;
                    r_rej      <= 1'b0;
                    r_idx      <= r_tgt_idx;
                    r_replaced <= ~r_empty_found;
                    r_state    <= DONE;
                end
                DONE: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wr_o       = (r_state == IDLE) ? wr_i : r_wr;
    assign add_ack_o  = r_ack;
    assign add_rej_o  = r_rej;
    assign add_idx_o  = r_idx;
    assign replaced_o = r_replaced;
    assign busy_o     = r_busy;

    initial assert (NUM_LEARNT >= 1);

endmodule

// File: tb/tb_learntc_slot_alloc.sv
// Directed bench for learntc_slot_alloc: expected acks and write pulses are queued
// when a request is driven and compared by a monitor when the DUT produces them.
module tb_learntc_slot_alloc;

    localparam int NC = 16;
    localparam int LW = 4;
    localparam int IW = 4;

    typedef struct {
        logic          rej;
        logic [IW-1:0] idx;
        logic          repl;
        int            cyc;
    } ack_exp_t;

    typedef struct {
        logic [NC-1:0] wr;
        int            cyc;
    } wr_exp_t;

    logic             clk;
    logic             rst;
    logic [NC-1:0]    wr_i;
    logic [NC-1:0]    wr_o;
    logic [NC*LW-1:0] clause_len_i;
    logic             add_req_i;
    logic [LW-1:0]    add_len_i;
    logic             add_ack_o;
    logic             add_rej_o;
    logic [IW-1:0]    add_idx_o;
    logic             replaced_o;
    logic             busy_o;
    logic [NC-1:0]    locked_i;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    ack_exp_t ack_q[$];
    wr_exp_t  wr_q[$];

    learntc_slot_alloc dut (
        .clk          (clk),
        .rst          (rst),
        .wr_i         (wr_i),
        .wr_o         (wr_o),
        .clause_len_i (clause_len_i),
        .add_req_i    (add_req_i),
        .add_len_i    (add_len_i),
        .add_ack_o    (add_ack_o),
        .add_rej_o    (add_rej_o),
        .add_idx_o    (add_idx_o),
        .replaced_o   (replaced_o),
        .busy_o       (busy_o),
        .locked_i     (locked_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every ack and every write pulse must match a queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (add_ack_o) begin
                check("ack_expected", 32'(ack_q.size() != 0), 32'd1);
                if (ack_q.size() != 0) begin
                    ack_exp_t e;
                    e = ack_q.pop_front();
                    check("ack_cycle", 32'(cyc), 32'(e.cyc));
                    check("ack_rej", 32'(add_rej_o), 32'(e.rej));
                    if (!e.rej) begin
                        check("ack_idx", 32'(add_idx_o), 32'(e.idx));
                        check("ack_replaced", 32'(replaced_o), 32'(e.repl));
                    end
                end
            end
            if (busy_o && (wr_o != '0)) begin
                check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    wr_exp_t w;
                    w = wr_q.pop_front();
                    check("wr_value", 32'(wr_o), 32'(w.wr));
                    check("wr_cycle", 32'(cyc), 32'(w.cyc));
                end
            end
        end
    end

    // Learnt lengths packed one nibble per slot, slot 8 in the low nibble.
    task automatic set_learnt(input logic [31:0] v);
        clause_len_i = {v, 32'h5555_5555};
    endtask

    // Drive one request; lat counts from the accepting IDLE cycle to the ack cycle.
    task automatic do_add(input logic [LW-1:0] len, input logic exp_rej, input int exp_idx,
                          input logic exp_repl, input int lat, input logic [NC-1:0] wr_bg,
                          input bit toggle_req);
        ack_exp_t e;
        wr_exp_t  w;
        bit       got;
        @(negedge clk);
        e.rej  = exp_rej;
        e.idx  = IW'(exp_idx);
        e.repl = exp_repl;
        e.cyc  = cyc + lat;
        ack_q.push_back(e);
        if (!exp_rej) begin
            w.wr  = NC'(1) << exp_idx;
            w.cyc = cyc + lat - 1;
            wr_q.push_back(w);
        end
        wr_i      = wr_bg;
        add_len_i = len;
        add_req_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("busy_in_scan", 32'(busy_o), 32'd1);
                check("wr_zero_in_scan", 32'(wr_o), 32'd0);
            end
            if (toggle_req && i == 1) add_req_i = 1'b0;
            if (toggle_req && i == 2) add_req_i = 1'b1;
            if (add_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        check("ack_within_budget", 32'(got), 32'd1);
        add_req_i = 1'b0;
        wr_i      = '0;
    endtask

    initial begin
        rst          = 1'b0;
        wr_i         = 16'h0003;
        add_req_i    = 1'b0;
        add_len_i    = '0;
        locked_i     = '0;
        clause_len_i = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(add_ack_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_wr_pass", 32'(wr_o), 32'h0003);
        rst = 1'b1;
        @(negedge clk);
        check("idle_rej", 32'(add_rej_o), 32'd0);
        check("idle_repl", 32'(replaced_o), 32'd0);
        check("idle_idx", 32'(add_idx_o), 32'd0);
        check("idle_wr_pass_3", 32'(wr_o), 32'h0003);
        wr_i = 16'hA5C3;
        #1;
        check("idle_wr_pass_a5c3", 32'(wr_o), 32'hA5C3);
        wr_i = '0;

        // First empty slot at learnt offset 2.
        set_learnt(32'h1111_1053);
        do_add(4'd4, 1'b0, 10, 1'b0, 5, '0, 1'b0);

        // Full region: longest is 7 at slots 9 and 11, lower index wins.
        set_learnt(32'h6541_7273);
        do_add(4'd4, 1'b0, 9, 1'b1, 11, '0, 1'b0);

        // Equal length is not shorter: reject.
        set_learnt(32'h3333_3333);
        do_add(4'd3, 1'b1, 0, 1'b0, 10, '0, 1'b0);

        // Length 0 is a normal length: replaces the first longest slot.
        do_add(4'd0, 1'b0, 8, 1'b1, 11, '0, 1'b0);

        // Empty at first and at last learnt slot.
        set_learnt(32'h2222_2220);
        do_add(4'd9, 1'b0, 8, 1'b0, 3, '0, 1'b0);
        set_learnt(32'h0222_2222);
        do_add(4'd1, 1'b0, 15, 1'b0, 10, '0, 1'b0);

        // wr_i ignored while busy, and a re-raised request during SCAN is not taken.
        set_learnt(32'h6541_7273);
        do_add(4'd2, 1'b0, 9, 1'b1, 11, 16'hFFFF, 1'b1);
        repeat (15) @(negedge clk);

        // Reset in the middle of a scan aborts the operation.
        add_len_i = 4'd1;
        add_req_i = 1'b1;
        repeat (5) @(negedge clk);
        rst       = 1'b0;
        add_req_i = 1'b0;
        wr_i      = 16'h0005;
        #1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_ack", 32'(add_ack_o), 32'd0);
        check("abort_wr_pass", 32'(wr_o), 32'h0005);
        @(negedge clk);
        rst  = 1'b1;
        wr_i = '0;
        repeat (15) @(negedge clk);
        check("abort_idle_busy", 32'(busy_o), 32'd0);

`ifdef LEARNTC_LOCK_EN
        locked_i = 16'h0A00;
        set_learnt(32'h6541_7273);
        do_add(4'd4, 1'b0, 15, 1'b1, 11, '0, 1'b0);
        locked_i = 16'hFF00;
        do_add(4'd0, 1'b1, 0, 1'b0, 10, '0, 1'b0);
        set_learnt(32'h1111_1053);
        do_add(4'd4, 1'b0, 10, 1'b0, 5, '0, 1'b0);
        locked_i = '0;
`endif

        repeat (10) @(negedge clk);
        check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/learntc_slot_alloc.md
Name: learntc_slot_alloc

Overview:
- Parametrised successor to the fixed 8-clause learnt-clause insertion logic.
- Sits between the SAT engine controller and the clause array. Owns the write-enable vector into the array.
- In normal mode it passes `wr_i` through to the array. On a learnt-clause add request it runs a sequential scan over the learnt region, picks a target slot, and issues one one-hot write.
- Slot choice: first empty slot, otherwise the longest stored clause. The add is rejected when the new clause is no shorter than every replaceable candidate.

Parameters:
- NUM_CLAUSES, 16, total clause slots in the array.
- NUM_ORIGIN, 8, slots 0..NUM_ORIGIN-1 hold original clauses and are never targeted. Learnt region is NUM_ORIGIN..NUM_CLAUSES-1; NUM_LEARNT = NUM_CLAUSES-NUM_ORIGIN, must be ≥1.
- WIDTH_C_LEN, 4, clause length width. Length 0 means the slot is empty.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_i  in  NUM_CLAUSES  normal-mode write enables from the controller.
- wr_o  out  NUM_CLAUSES  write enables to the clause array.
- clause_len_i  in  NUM_CLAUSES*WIDTH_C_LEN  per-slot stored lengths from the array. Slot k occupies bits [k*WIDTH_C_LEN +: WIDTH_C_LEN].
- add_req_i  in  1  learnt-clause add request; held high until ack.
- add_len_i  in  WIDTH_C_LEN  length of the clause to add. Sampled when the request is accepted.
- add_ack_o  out  1  one-cycle pulse: request finished.
- add_rej_o  out  1  valid with ack. 1 = no slot written.
- add_idx_o  out  $clog2(NUM_CLAUSES)  slot written; valid with ack when add_rej_o=0.
- replaced_o  out  1  valid with ack. 1 = a non-empty clause was overwritten.
- busy_o  out  1  high in any state other than IDLE.
- locked_i  in  NUM_CLAUSES  slot is a live reason clause. Used only with the optional feature.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - add_ack_o, add_rej_o, replaced_o, busy_o = 0; add_idx_o = 0.
  - All internal registers cleared.
  - wr_o follows the IDLE rule below.
  - Reset mid-scan or mid-write aborts the operation: no write, no ack.
- FSM states: IDLE, SCAN, WRITE, DONE.
- IDLE:
  - wr_o = wr_i, combinational pass-through.
  - If add_req_i=1: register add_len_i; ptr = NUM_ORIGIN; best_len = 0; best_vld = 0; empty_found = 0. Go to SCAN.
- SCAN (one slot per cycle, slot = ptr):
  - wr_o = 0; wr_i is ignored.
  - If len[ptr]==0: record ptr as target, set empty_found, go to WRITE. This early-terminates the scan.
  - Else if the slot is eligible and (len[ptr] > best_len or best_vld=0): best_len = len[ptr], best_idx = ptr, best_vld = 1. Strict ">" means ties keep the lowest index.
  - If ptr == NUM_CLAUSES-1 with no empty slot found: go to WRITE if best_vld and add_len < best_len, else go to DONE with rejection.
  - Otherwise ptr++.
- WRITE:
  - wr_o = one-hot of the target slot for exactly one cycle.
  - Go to DONE.
- DONE:
  - add_ack_o = 1 for one cycle with add_rej_o, add_idx_o and replaced_o valid.
  - replaced_o = ~empty_found on success.
  - add_idx_o holds its value until the next ack.
  - Go to IDLE.
- Latency, request accepted to ack:
  - Empty slot at learnt offset k: k+3 cycles.
  - Full scan: NUM_LEARNT+2 cycles on reject, NUM_LEARNT+3 on write.
- Handshake:
  - add_req_i is ignored while busy_o=1.
  - The controller drops req in the ack cycle. If req is still high in the first IDLE cycle after DONE, a new request is accepted.
- Eligibility:
  - Every non-empty learnt slot is eligible unless LEARNTC_LOCK_EN is defined.
- Width and boundary rules:
  - Length comparisons are unsigned at WIDTH_C_LEN.
  - add_len_i = 0 is accepted and treated as a normal length.
  - ptr width is $clog2(NUM_CLAUSES); ptr never wraps.
  - NUM_LEARNT = 1 is legal: single-cycle scan.

Optional Feature:
- Macro: LEARNTC_LOCK_EN.
- Defined: a slot with locked_i[k]=1 is not eligible for replacement. Empty slots remain usable regardless of locked_i. If every non-empty learnt slot is locked and none is empty, the request is rejected. locked_i is sampled per slot during SCAN.
- Undefined: locked_i is unused and all non-empty learnt slots are eligible.

Decomposition:
- Shared package sat_cfg_pkg holds:
  - FSM state typedef (IDLE/SCAN/WRITE/DONE).
  - Default WIDTH_C_LEN.
  - The EMPTY_LEN=0 constant.
  - A function for slot length extraction.
- One sub-module, len_max_tracker: registered running max with index and eligibility input, reused by the SCAN state.

Test Plan:
- Empty slot: NUM_CLAUSES=16, NUM_ORIGIN=8, lens 8..15 = {3,5,0,…}, req len 4 → wr_o = 0x0400 for one cycle, ack at cycle 5, idx=10, rej=0, replaced=0.
- Full region, replace longest: learnt lens {3,7,2,7,1,4,5,6}, req len 4 → write slot 9 (tie with slot 11 goes to the lower index), replaced=1, ack at cycle 11.
- Reject: all learnt lens = 3, req len 3 → no wr_o pulse, ack at cycle 10 with rej=1.
- Pass-through and request ignored while busy: wr_i=0x0003 in IDLE → wr_o=0x0003. A second req during SCAN is not accepted and no second ack appears. During SCAN, wr_o=0 even with wr_i≠0.
- Reset abort: deassert rst at the SCAN midpoint → wr_o never pulses, no ack, busy_o=0, FSM in IDLE.
- LEARNTC_LOCK_EN: lens as in the second test with locked_i[9]=locked_i[11]=1 → write slot 15 (len 6). All slots locked → rej=1.
